// File: rtl/vote_rx_pkg.sv
// Shared types and sample-point helpers for the vote_rx oversampling serial receiver.
package vote_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Three consecutive mid-bit sample points, counted from the bit's first tick.
    function automatic int sample_a(input int osr);
        return osr / 2 - 1;
    endfunction

    function automatic int sample_b(input int osr);
        return osr / 2;
    endfunction

    function automatic int sample_c(input int osr);
        return osr / 2 + 1;
    endfunction

endpackage

// File: rtl/vote_rx_majority.sv
// Three-input majority voter used by vote_rx to vote each serial bit.
module majority (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic m
);

    assign m = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/vote_rx.sv
// Oversampling serial receiver: three mid-bit samples voted by majority, framed into words.
// Optional build macro NOISE_FLAG_EN adds the noise_err output and per-frame noise flag.
module vote_rx
    import vote_rx_pkg::*;
#(
    parameter int OSR    = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
`ifdef NOISE_FLAG_EN
    ,
    output logic              noise_err
`endif
);

    localparam int TICK_W = $clog2(OSR);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [TICK_W-1:0] SAMPLE_A  = TICK_W'(sample_a(OSR));
    localparam logic [TICK_W-1:0] SAMPLE_B  = TICK_W'(sample_b(OSR));
    localparam logic [TICK_W-1:0] SAMPLE_C  = TICK_W'(sample_c(OSR));
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    logic              rxd_m_reg, rxd_s_reg, rxd_p_reg;
    state_t            state_reg, state_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [BIT_W-1:0]  bit_idx_reg, bit_idx_next;
    logic              a_reg, b_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              m;

    logic edge_seen, vote_now, shift_en, stop_vote, accept, load_word, drop_word, bad_stop;

    assign edge_seen = !rxd_s_reg && rxd_p_reg;
    assign vote_now  = (state_reg != IDLE) && (tick_reg == SAMPLE_C);

    // The third sample is taken live so the vote lands in the same cycle as sample c.
    majority u_majority (
        .a (a_reg),
        .b (b_reg),
        .c (rxd_s_reg),
        .m (m)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            bit_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_idx_reg <= bit_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        case (state_reg)
            IDLE:  if (edge_seen) state_next = START;
            START: begin
                bit_idx_next = '0;
                if (vote_now && m) state_next = IDLE;
                else if (tick_reg == TICK_LAST) state_next = DATA;
            end
            DATA: begin
                if (tick_reg == TICK_LAST) begin
                    bit_idx_next = bit_idx_reg + BIT_W'(1);
                    if (bit_idx_reg == BIT_LAST) state_next = STOP;
                end
            end
            STOP:  if (vote_now) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The edge cycle itself is tick 0, so counting resumes at 1 on entry to START.
        if (state_next == IDLE || tick_reg == TICK_LAST) tick_next = '0;
        else tick_next = tick_reg + TICK_W'(1);
    end

    always_comb begin
        shift_en  = (state_reg == DATA) && vote_now;
        stop_vote = (state_reg == STOP) && vote_now;
        accept    = out_valid && out_ready;
        load_word = stop_vote && m && (!out_valid || out_ready);
        drop_word = stop_vote && m && out_valid && !out_ready;
        bad_stop  = stop_vote && !m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m_reg <= 1'b1;
            rxd_s_reg <= 1'b1;
            rxd_p_reg <= 1'b1;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            shift_reg <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rxd_m_reg <= rxd;
            rxd_s_reg <= rxd_m_reg;
            rxd_p_reg <= rxd_s_reg;
            if (tick_reg == SAMPLE_A) a_reg <= rxd_s_reg;
            if (tick_reg == SAMPLE_B) b_reg <= rxd_s_reg;
            if (shift_en) shift_reg <= {m, shift_reg[DATA_W-1:1]};
            frame_err <= bad_stop;
            overrun   <= drop_word;
            if (load_word) begin
                out_data  <= shift_reg;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NOISE_FLAG_EN
    logic noise_seen_reg;
    logic noisy_vote;

    assign noisy_vote = vote_now && !((a_reg == b_reg) && (b_reg == rxd_s_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            noise_seen_reg <= 1'b0;
            noise_err      <= 1'b0;
        end else begin
            if (state_reg == IDLE && edge_seen) noise_seen_reg <= 1'b0;
            else if (noisy_vote) noise_seen_reg <= 1'b1;
            if (load_word) noise_err <= noise_seen_reg | noisy_vote;
            else if (accept) noise_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vote_rx.sv
// Directed bench for vote_rx (OSR=16, DATA_W=8); define NOISE_FLAG_EN to also check noise_err.
module tb_vote_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid, frame_err, overrun;
`ifdef NOISE_FLAG_EN
    logic       noise_err;
`endif

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int acc_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, vhigh_cnt = 0, rise_cyc = 0;
    logic [7:0] last_word = 8'h00;
    logic       last_noise = 1'b0;
    logic       prev_valid = 1'b0;
    int start_cyc;

    vote_rx #(.OSR(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef NOISE_FLAG_EN
        ,
        .noise_err (noise_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                acc_cnt   <= acc_cnt + 1;
                last_word <= out_data;
`ifdef NOISE_FLAG_EN
                last_noise <= noise_err;
`endif
            end
            if (out_valid) vhigh_cnt <= vhigh_cnt + 1;
            if (out_valid && !prev_valid) rise_cyc <= cyc;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            prev_valid <= out_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit, 16 cycles each;
    // glitch_k >= 0 inverts the line for the single cycle with that index.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch_k);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        @(posedge clk); #1;
        start_cyc = cyc;
        for (int k = 0; k < 160; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            rxd = bits[k / 16] ^ (k == glitch_k);
        end
        @(posedge clk); #1;
        rxd = 1'b1;
        $display("frame 0x%02h stop=%0b glitch=%0d sent", d, stop_bit, glitch_k);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0, ferr0, ovr0, vh0;
        logic [9:0] pbits;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data", {24'd0, out_data}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_ovr", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // Clean 0xA5: one-cycle valid pulse, 156 cycles after the first low drive.
        acc0 = acc_cnt; ferr0 = ferr_cnt; vh0 = vhigh_cnt;
        send_frame(8'hA5, 1'b1, -1);
        idle(10);
        check("a5_count", acc_cnt - acc0, 1);
        check("a5_data", {24'd0, last_word}, 32'hA5);
        check("a5_latency", rise_cyc - start_cyc, 156);
        check("a5_pulse", vhigh_cnt - vh0, 1);
        check("a5_ferr", ferr_cnt - ferr0, 0);

        // 0x00 with a one-cycle high glitch at sample b of data bit 3.
        acc0 = acc_cnt;
        send_frame(8'h00, 1'b1, 72);
        idle(10);
        check("glitch_count", acc_cnt - acc0, 1);
        check("glitch_data", {24'd0, last_word}, 32'h00);
`ifdef NOISE_FLAG_EN
        check("glitch_noise", {31'd0, last_noise}, 32'd1);
        send_frame(8'h00, 1'b1, -1);
        idle(10);
        check("clean_noise", {31'd0, last_noise}, 32'd0);
`endif

        // False start: 4 low cycles then high.
        acc0 = acc_cnt; ferr0 = ferr_cnt;
        @(posedge clk); #1 rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(200);
        $display("false start sent");
        check("false_count", acc_cnt - acc0, 0);
        check("false_ferr", ferr_cnt - ferr0, 0);

        // 0x5A with a zero stop bit.
        acc0 = acc_cnt; ferr0 = ferr_cnt;
        send_frame(8'h5A, 1'b0, -1);
        idle(20);
        check("ferr_count", ferr_cnt - ferr0, 1);
        check("ferr_nodata", acc_cnt - acc0, 0);
        check("ferr_valid", {31'd0, out_valid}, 32'd0);

        // 0x11 then 0x22 with the sink stalled.
        out_ready = 1'b0;
        acc0 = acc_cnt; ovr0 = ovr_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(5);
        @(negedge clk);
        check("ovr_valid", {31'd0, out_valid}, 32'd1);
        check("ovr_data", {24'd0, out_data}, 32'h11);
        check("ovr_count", ovr_cnt - ovr0, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("ovr_accept", acc_cnt - acc0, 1);
        check("ovr_word", {24'd0, last_word}, 32'h11);
        check("ovr_cleared", {31'd0, out_valid}, 32'd0);

        // Hold a word, then reset in the middle of data bit 4 of another frame.
        out_ready = 1'b0;
        send_frame(8'h99, 1'b1, -1);
        idle(5);
        pbits = {1'b1, 8'hF0, 1'b0};
        @(posedge clk); #1 rxd = 1'b0;
        for (int k = 1; k < 84; k++) begin
            @(posedge clk); #1;
            rxd = pbits[k / 16];
        end
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        $display("reset asserted mid-frame");
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rxd = 1'b1;
        out_ready = 1'b1;
        idle(20);
        acc0 = acc_cnt;
        send_frame(8'h3C, 1'b1, -1);
        idle(10);
        check("post_rst_count", acc_cnt - acc0, 1);
        check("post_rst_data", {24'd0, last_word}, 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
